spi_target_port: RTL and testbench

//  SPI mode-0 responder (target) giving an external host byte-wide register access to the core.
//  - Is the other end of the chip's SPI controller link.
//  - Sits inside chip_core on user_io bidir pads: sclk, cs_n and mosi in; miso out with oe.
//  - All pad inputs are oversampled on clk; there is no second clock domain.

---
 rtl/spi_target_pkg.sv | 25 ++
 rtl/spi_target_sync.sv | 40 ++++
 rtl/spi_target_port.sv | 207 ++++++++++++++++++++
 tb/tb_spi_target_port.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_target_pkg.sv
// rtl/spi_target_pkg.sv - shared types and constants for the SPI target port
//
// Purpose: FSM state encoding, command-byte layout and byte geometry used by
//          spi_target_port and its helpers.
// Ports:   none (package).

package spi_target_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    WDATA   = 3'd2,
    RDATA   = 3'd3,
    LOCKOUT = 3'd4
  } state_t;

  localparam int CMD_WRITE_BIT = 7;
  localparam int BYTE_BITS     = 8;

  // States in which SCLK edges are consumed.
  function automatic logic is_active(input state_t s);
    return (s == CMD) || (s == WDATA) || (s == RDATA);
  endfunction

endpackage

// File: rtl/spi_target_sync.sv
// rtl/spi_target_sync.sv - multi-flop input synchronizer with edge detect
//
// Purpose: brings one raw pad input into the clk domain and flags its edges.
// Ports:
//   clk, rst_n  system clock, asynchronous active-low reset
//   d           raw asynchronous input
//   level       synchronized level
//   rise, fall  1-clk pulses on synchronized 0->1 / 1->0 transitions
// All flops reset to 0, so a line that is already low when reset releases
// never shows a fall.

module spi_target_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/spi_target_port.sv
// rtl/spi_target_port.sv - SPI mode-0 target giving a host byte-wide register access
//
// Purpose: oversamples sclk/cs_n/mosi on clk, decodes a command byte
//          (bit7 write / read, bits[6:0] start address) followed by data
//          bytes with auto-incrementing address, and drives a simple
//          register strobe interface.
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   spi_sclk/cs_n/mosi    raw pad inputs
//   spi_miso, spi_miso_oe serial data to host and its pad enable
//   reg_addr, reg_wdata   register address / write data
//   reg_we, reg_re        1-clk write / read strobes
//   reg_rdata             read data, captured the clk after reg_re
//   busy                  frame in progress
//   frame_err             1-clk pulse on an aborted frame
// Optional feature: SPI_TARGET_TIMEOUT_EN enables the stalled-SCLK abort.

module spi_target_port
  import spi_target_pkg::*;
#(
  parameter int ADDR_W         = 7,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              busy,
  output logic              frame_err
);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  spi_target_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(spi_sclk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_target_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .d(spi_cs_n),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  spi_target_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d(spi_mosi),
    .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
  );

  logic unused_sync;
  assign unused_sync = &{1'b0, sclk_lvl, mosi_rise, mosi_fall};

  state_t            state, state_nxt;
  logic              armed;
  logic [2:0]        bit_cnt;
  logic [7:0]        rx_shift;
  logic [7:0]        tx_shift;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        rx_byte;
  logic [ADDR_W-1:0] cmd_addr;
  logic              active;
  logic              byte_done;
  logic              cs_start;
  logic              timeout_hit;

  assign active    = is_active(state);
  assign rx_byte   = {rx_shift[BYTE_BITS-2:0], mosi_lvl};
  assign cmd_addr  = rx_byte[ADDR_W-1:0];
  assign byte_done = active & sclk_rise & (bit_cnt == 3'(BYTE_BITS - 1));

  // armed stays low after reset until CS has been seen high, so a frame that
  // was already running when reset released is ignored to its end.
  assign cs_start  = (state == IDLE) & armed & cs_fall;
  assign busy      = armed & ~cs_lvl;

`ifdef SPI_TARGET_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (!active || sclk_rise || sclk_fall || cs_start) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + TW'(1);
    end
  end

  // Fires after TIMEOUT_CYCLES consecutive clks with no SCLK edge.
  assign timeout_hit = active & ~cs_rise & ~sclk_rise & ~sclk_fall &
                       (to_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign spi_miso_oe = busy & (state != LOCKOUT);
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
  assign spi_miso_oe = busy;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_start) state_nxt = CMD;
      CMD:     if (byte_done) state_nxt = rx_byte[CMD_WRITE_BIT] ? WDATA : RDATA;
      WDATA:   state_nxt = WDATA;
      RDATA:   state_nxt = RDATA;
      LOCKOUT: state_nxt = LOCKOUT;
      default: state_nxt = IDLE;
    endcase
    if (timeout_hit) state_nxt = LOCKOUT;
    if (cs_rise)     state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed     <= 1'b0;
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      addr      <= '0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      spi_miso  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      frame_err <= 1'b0;

      if (cs_lvl) armed <= 1'b1;

      if (active && sclk_rise) begin
        rx_shift <= rx_byte;
        bit_cnt  <= bit_cnt + 3'd1;
      end

      if ((state == RDATA) && sclk_fall) begin
        spi_miso <= tx_shift[BYTE_BITS-1];
        tx_shift <= {tx_shift[BYTE_BITS-2:0], 1'b0};
      end

      // Read data arrives the clk after the strobe; it lands well before the
      // SCLK fall that presents its MSB.
      if (reg_re) tx_shift <= reg_rdata;

      // Reads are prefetched at the end of the previous byte; a byte that
      // completes as CS rises has no following byte, so no prefetch then.
      if (byte_done) begin
        case (state)
          CMD: begin
            if (rx_byte[CMD_WRITE_BIT]) begin
              addr <= cmd_addr;
            end else if (!cs_rise) begin
              reg_addr <= cmd_addr;
              reg_re   <= 1'b1;
              addr     <= cmd_addr + ADDR_W'(1);
            end
          end
          WDATA: begin
            reg_addr  <= addr;
            reg_wdata <= rx_byte;
            reg_we    <= 1'b1;
            addr      <= addr + ADDR_W'(1);
          end
          RDATA: begin
            if (!cs_rise) begin
              reg_addr <= addr;
              reg_re   <= 1'b1;
              addr     <= addr + ADDR_W'(1);
            end
          end
          default: ;
        endcase
      end

      if (cs_rise && active && (bit_cnt != 3'd0) && !byte_done) frame_err <= 1'b1;
      if (timeout_hit) frame_err <= 1'b1;

      if (!is_active(state_nxt)) begin
        bit_cnt  <= '0;
        rx_shift <= '0;
        spi_miso <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_target_port.sv
// tb/tb_spi_target_port.sv - scoreboard bench for spi_target_port

module tb_spi_target_port;

  localparam int HALF = 80;
  localparam int TO   = 256;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_sclk = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso, spi_miso_oe, reg_we, reg_re, busy, frame_err;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata, reg_rdata;

  spi_target_port #(.ADDR_W(7), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] a;
    logic [7:0] d;
  } wr_t;

  logic [7:0] regs      [128];
  logic [7:0] model_mem [128];
  logic       regs_ready = 1'b0;
  wr_t        exp_wr [$];
  logic [6:0] exp_rd [$];
  int         err_exp = 0;
  int         err_seen = 0;
  int         n_vec = 0;
  int         n_bad = 0;
  wr_t        mon_w;
  logic [6:0] mon_a;

  assign reg_rdata = regs[reg_addr];

  function automatic logic [7:0] init_val(input int i);
    if (i == 127) return 8'h3C;
    if (i == 0)   return 8'h11;
    return 8'(i * 37 + 5);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: register file on the DUT side plus scoreboard pops.
  always @(negedge clk) begin
    if (!regs_ready) begin
      for (int i = 0; i < 128; i++) regs[i] = init_val(i);
      regs_ready = 1'b1;
    end
    if (rst_n) begin
      if (reg_we || reg_re) chk("we_re_exclusive", int'(reg_we && reg_re), 0);
      if (reg_we) begin
        if (exp_wr.size() == 0) chk("unexpected_we", 1, 0);
        else begin
          mon_w = exp_wr.pop_front();
          chk("we_addr", reg_addr, mon_w.a);
          chk("we_data", reg_wdata, mon_w.d);
        end
        regs[reg_addr] = reg_wdata;
      end
      if (reg_re) begin
        if (exp_rd.size() == 0) chk("unexpected_re", 1, 0);
        else begin
          mon_a = exp_rd.pop_front();
          chk("re_addr", reg_addr, mon_a);
        end
      end
      if (frame_err) begin
        chk("frame_err_expected", int'(err_seen < err_exp), 1);
        err_seen++;
      end
    end
  end

  task automatic cs_low();
    spi_cs_n = 1'b0;
    #(HALF);
  endtask

  task automatic cs_high();
    #(HALF);
    spi_cs_n = 1'b1;
    #(HALF * 2);
  endtask

  // Host samples MISO just before each rising edge.
  task automatic xfer(input logic [7:0] b, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < n; i++) begin
      spi_mosi = b[7-i];
      #(HALF);
      rx[7-i] = spi_miso;
      spi_sclk = 1'b1;
      #(HALF);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic do_frame(input logic wr, input logic [6:0] a, input logic [7:0] dq[$],
                          input int partial);
    logic [7:0] rx;
    logic [6:0] ak;
    wr_t        w;
    if (!wr) exp_rd.push_back(a);
    cs_low();
    xfer({wr, a}, 8, rx);
    chk("cmd_miso", rx, 0);
    for (int k = 0; k < dq.size(); k++) begin
      ak = a + 7'(k);
      if (wr) begin
        w.a = ak;
        w.d = dq[k];
        exp_wr.push_back(w);
        model_mem[ak] = dq[k];
        xfer(dq[k], 8, rx);
        chk("wr_miso", rx, 0);
      end else begin
        exp_rd.push_back(ak + 7'd1);
        xfer(dq[k], 8, rx);
        chk("rd_miso", rx, model_mem[ak]);
      end
    end
    if (partial > 0) begin
      err_exp++;
      xfer(8'($urandom), partial, rx);
    end
    cs_high();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_miso"}, spi_miso, 0);
    chk({tag, "_oe"}, spi_miso_oe, 0);
    chk({tag, "_addr"}, reg_addr, 0);
    chk({tag, "_wdata"}, reg_wdata, 0);
    chk({tag, "_we"}, reg_we, 0);
    chk({tag, "_re"}, reg_re, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ferr"}, frame_err, 0);
  endtask

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       r_wr;
    logic [6:0] r_a;
    int         r_n, r_p;
    logic [7:0] dq [$];
    logic [7:0] rx;

    for (int i = 0; i < 128; i++) model_mem[i] = init_val(i);
    #23;
    chk_zero("reset");
    #7;
    rst_n = 1'b1;
    #100;

    do_frame(1'b1, 7'h05, '{8'hAA, 8'h55}, 0);
    do_frame(1'b0, 7'h7F, '{8'h00, 8'h00}, 0);
    do_frame(1'b1, 7'h01, '{8'hF0}, 5);
    do_frame(1'b1, 7'h03, '{}, 0);

    // Abort inside the command byte.
    err_exp++;
    cs_low();
    xfer(8'h9A, 3, rx);
    cs_high();

    // Reset in the middle of a read; the frame continues with CS low.
    exp_rd.push_back(7'h10);
    cs_low();
    xfer(8'h10, 8, rx);
    chk("cmd_miso", rx, 0);
    xfer(8'hA5, 3, rx);
    rst_n = 1'b0;
    #23;
    chk_zero("midrst");
    rst_n = 1'b1;
    #7;
    xfer(8'h3C, 8, rx);
    chk("post_rst_miso", rx, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_oe", spi_miso_oe, 0);
    cs_high();
    do_frame(1'b0, 7'h10, '{8'h00}, 0);

`ifdef SPI_TARGET_TIMEOUT_EN
    err_exp++;
    cs_low();
    xfer(8'h85, 3, rx);
    #((TO + 20) * 10);
    chk("timeout_oe", spi_miso_oe, 0);
    chk("timeout_err_seen", err_seen, err_exp);
    xfer(8'hFF, 8, rx);
    xfer(8'h12, 8, rx);
    cs_high();
    do_frame(1'b1, 7'h40, '{8'h77}, 0);
`endif

    for (int f = 0; f < 24; f++) begin
      r_wr = 1'($urandom_range(0, 1));
      r_a  = 7'($urandom);
      r_n  = $urandom_range(1, 4);
      r_p  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      dq   = {};
      for (int k = 0; k < r_n; k++) dq.push_back(8'($urandom));
      do_frame(r_wr, r_a, dq, r_p);
    end

    #(HALF * 4);
    chk("pending_writes", exp_wr.size(), 0);
    chk("pending_reads", exp_rd.size(), 0);
    chk("frame_err_count", err_seen, err_exp);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
